// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers (a, b, last) operand pairs from a valid/ready
// producer in a small FIFO. It streams one pair per cycle into an 8x8 MAC and
// pulses out_HL once to close each dot-product vector. A vector closes on
// last=1 or after MAX_LEN pairs; a close without last sets len_err.
// Optional feature: define SEQ_VEC_COUNT_EN to add the vec_count output.
// vec_count counts closed vectors and wraps at 2^CNT_W.
module mac_operand_sequencer #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              out_HL,
    input  logic              mac_error,
    output logic              err_sticky,
    output logic              len_err,
    output logic              busy
`ifdef SEQ_VEC_COUNT_EN
    ,
    output logic [CNT_W-1:0]  vec_count
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CLOSE  = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t            state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem_a    [DEPTH];
    logic [DATA_W-1:0] mem_b    [DEPTH];
    logic              mem_last [DEPTH];
    logic [LEN_W-1:0]  pair_cnt;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic              head_last;
    logic              close_now;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // in_ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    // It is held low while reset is asserted.
    assign in_ready  = reset && !full;
    assign push      = in_valid && in_ready;
    assign pop       = (state == STREAM) && !empty;
    assign head_a    = mem_a[rd_ptr[AW-1:0]];
    assign head_b    = mem_b[rd_ptr[AW-1:0]];
    assign head_last = mem_last[rd_ptr[AW-1:0]];
    assign close_now = pop && (head_last || (pair_cnt == LEN_W'(MAX_LEN - 1)));
    assign busy      = !empty || (state != IDLE);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]]    <= in_a;
            mem_b[wr_ptr[AW-1:0]]    <= in_b;
            mem_last[wr_ptr[AW-1:0]] <= in_last;
        end
    end

    // FIFO pointers; a reset drops any queued pairs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Sequencer FSM with registered MAC-facing outputs; outputs lag the state by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            out_HL   <= 1'b0;
            pair_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_a   <= '0;
                    op_b   <= '0;
                    out_HL <= 1'b0;
                    if (!empty) state <= STREAM;
                end
                STREAM: begin
                    out_HL <= 1'b0;
                    if (!empty) begin
                        op_a <= head_a;
                        op_b <= head_b;
                        if (close_now) begin
                            state    <= CLOSE;
                            pair_cnt <= '0;
                            if (!head_last) len_err <= 1'b1;
                        end else begin
                            pair_cnt <= pair_cnt + LEN_W'(1);
                        end
                    end else begin
                        // Null product keeps the MAC accumulator unchanged while starved.
                        op_a <= '0;
                        op_b <= '0;
                    end
                end
                CLOSE: begin
                    op_a   <= '0;
                    op_b   <= '0;
                    out_HL <= 1'b1;
                    state  <= GAP;
                end
                GAP: begin
                    op_a   <= '0;
                    op_b   <= '0;
                    out_HL <= 1'b0;
                    state  <= empty ? IDLE : STREAM;
                end
                default: begin
                    op_a   <= '0;
                    op_b   <= '0;
                    out_HL <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Sticky MAC error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) err_sticky <= 1'b0;
        else        err_sticky <= err_sticky | mac_error;
    end

`ifdef SEQ_VEC_COUNT_EN
    // Closed-vector counter; increments once per CLOSE cycle and wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset)              vec_count <= '0;
        else if (state == CLOSE) vec_count <= vec_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer (DEPTH=4, MAX_LEN=16).
// The reference model works at the level of transferred pairs and a MAC.
// Each accepted pair adds a*b to the open vector. The vector closes on last or
// at MAX_LEN pairs, giving an expected dot product. A model MAC accumulates
// op_a*op_b and is checked against that value on every out_HL pulse.
// Data are nonzero, so a nonzero operand marks a FIFO pop.
// FIFO occupancy therefore follows from accepted pushes and observed pops.
module tb_mac_operand_sequencer;

    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       out_HL;
    logic       mac_error;
    logic       err_sticky;
    logic       len_err;
    logic       busy;
`ifdef SEQ_VEC_COUNT_EN
    logic [7:0] vec_count;
`endif

    mac_operand_sequencer #(
        .DATA_W(8), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .op_a(op_a), .op_b(op_b), .out_HL(out_HL), .mac_error(mac_error),
        .err_sticky(err_sticky), .len_err(len_err), .busy(busy)
`ifdef SEQ_VEC_COUNT_EN
        , .vec_count(vec_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int occ;
    int cur_len;
    int cur_sum;
    int exp_sum[$];
    bit exp_forced[$];
    int acc;
    int last_result;
    int hl_cnt;
    bit prev_hl;
    bit lenerr_exp;
    bit err_exp;
    bit saw_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        occ = 0; cur_len = 0; cur_sum = 0; acc = 0; hl_cnt = 0;
        prev_hl = 0; lenerr_exp = 0; err_exp = 0;
        exp_sum.delete();
        exp_forced.delete();
    endtask

    task automatic model_push(input int a, input int b, input bit l);
        occ++;
        cur_len++;
        cur_sum += a * b;
        if (l || cur_len == MAX_LEN) begin
            exp_sum.push_back(cur_sum);
            exp_forced.push_back(!l);
            cur_len = 0;
            cur_sum = 0;
        end
    endtask

    task automatic observe();
        bit p;
        p = (op_a != 8'd0);
        if (p) occ--;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (occ != DEPTH)});
        if (!in_ready) saw_full = 1;
        chk("op_pair_zero", {31'd0, (op_b == 8'd0)}, {31'd0, !p});
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, err_exp});
        if (out_HL) begin
            chk("hl_ops_zero", {24'd0, op_a}, 32'd0);
            chk("hl_consecutive", {31'd0, prev_hl}, 32'd0);
            total++;
            assert (exp_sum.size() != 0) else begin
                bad++;
                $error("FAIL hl_unexpected observed=pulse expected=none");
            end
            if (exp_sum.size() != 0) begin
                chk("mac_sum", acc, exp_sum.pop_front());
                if (exp_forced.pop_front()) lenerr_exp = 1;
                chk("len_err", {31'd0, len_err}, {31'd0, lenerr_exp});
            end
            last_result = acc;
            acc = 0;
            hl_cnt++;
        end else begin
            acc += int'(op_a) * int'(op_b);
        end
`ifdef SEQ_VEC_COUNT_EN
        chk("vec_count", {24'd0, vec_count}, hl_cnt % 256);
`endif
        prev_hl = out_HL;
    endtask

    // One clock: sample the handshake mid-cycle, then check just after the edge.
    task automatic step(output bit fired);
        bit f, l, r, me;
        int a, b;
        @(negedge clk);
        f = in_valid && in_ready; a = in_a; b = in_b; l = in_last;
        r = !reset; me = mac_error;
        @(posedge clk);
        #1;
        fired = f;
        if (r) begin
            model_reset();
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_ops", {16'd0, op_a, op_b}, 32'd0);
            chk("rst_out_HL", {31'd0, out_HL}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
            chk("rst_len_err", {31'd0, len_err}, 32'd0);
        end else begin
            if (f) model_push(a, b, l);
            if (me) err_exp = 1;
            observe();
        end
    endtask

    task automatic tick();
        bit f;
        step(f);
    endtask

    // Present one pair and hold in_valid until it is accepted (bounded).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit l);
        bit f;
        int guard;
        in_valid = 1; in_a = a; in_b = b; in_last = l;
        guard = 0;
        do begin
            step(f);
            guard++;
        end while (!f && guard < 100);
        if (!f) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int guard;
        in_valid = 0;
        guard = 0;
        while (busy && guard < 300) begin
            tick();
            guard++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_pending", exp_sum.size(), 32'd0);
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(255, 1));
    endfunction

    initial begin
        int base;
        int len;
        reset = 0; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; mac_error = 0;
        model_reset();
        last_result = 0;
        saw_full = 0;
        tick();
        tick();
        reset = 1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // single-pair vector: exact latency
        send(8'd13, 8'd15, 1'b1);
        in_valid = 0;
        tick();
        chk("t1_op_a_early", {24'd0, op_a}, 32'd0);
        tick();
        chk("t1_op_a", {24'd0, op_a}, 32'd13);
        chk("t1_op_b", {24'd0, op_b}, 32'd15);
        chk("t1_hl_early", {31'd0, out_HL}, 32'd0);
        tick();
        chk("t1_out_HL", {31'd0, out_HL}, 32'd1);
        chk("t1_result", last_result, 32'd195);
        drain();

        // two-pair vector, back-to-back
        send(8'd13, 8'd15, 1'b0);
        send(8'd41, 8'd47, 1'b1);
        in_valid = 0;
        tick();
        chk("t2_op_a0", {24'd0, op_a}, 32'd13);
        tick();
        chk("t2_op_a1", {24'd0, op_a}, 32'd41);
        chk("t2_op_b1", {24'd0, op_b}, 32'd47);
        tick();
        chk("t2_out_HL", {31'd0, out_HL}, 32'd1);
        chk("t2_result", last_result, 32'd2122);
        drain();

        // continuous producer: 12 pairs, 3 vectors, FIFO must fill
        base = hl_cnt;
        saw_full = 0;
        for (int i = 0; i < 12; i++) send(rnd8(), rnd8(), (i % 4) == 3);
        drain();
        chk("t3_saw_full", {31'd0, saw_full}, 32'd1);
        chk("t3_pulses", hl_cnt - base, 32'd3);

        // 17 pairs without last: forced close at MAX_LEN
        base = hl_cnt;
        for (int i = 0; i < 17; i++) send(rnd8(), rnd8(), 1'b0);
        send(rnd8(), rnd8(), 1'b1);
        drain();
        chk("t4_len_err", {31'd0, len_err}, 32'd1);
        chk("t4_pulses", hl_cnt - base, 32'd2);

        // one-cycle MAC error pulse latches
        mac_error = 1;
        tick();
        mac_error = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_err_sticky", {31'd0, err_sticky}, 32'd1);

        // reset mid-vector with entries queued
        send(rnd8(), rnd8(), 1'b1);
        for (int i = 0; i < 4; i++) send(rnd8(), rnd8(), 1'b0);
        in_valid = 0;
        tick();
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        reset = 0;
        tick();
        reset = 1;
        tick();
        chk("t5_ops", {16'd0, op_a, op_b}, 32'd0);
        chk("t5_out_HL", {31'd0, out_HL}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_err_sticky", {31'd0, err_sticky}, 32'd0);
        chk("t5_len_err", {31'd0, len_err}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_no_pulse", hl_cnt, 32'd0);

        // randomized vectors with producer gaps
        base = hl_cnt;
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                in_valid = 0;
                while ($urandom_range(3, 0) == 0) tick();
                send(rnd8(), rnd8(), k == len - 1);
            end
        end
        drain();
        chk("rand_pulses", hl_cnt - base, 32'd40);
        chk("rand_len_err", {31'd0, len_err}, 32'd0);

`ifdef SEQ_VEC_COUNT_EN
        // counter wrap past 255
        for (int v = 0; v < 260; v++) send(rnd8(), rnd8(), 1'b1);
        drain();
        chk("wrap_vec_count", {24'd0, vec_count}, hl_cnt % 256);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
